// File: rtl/pipe_stall_ctrl.sv
// Pipeline control unit: merges stage hold requests into a hold/bubble vector,
// sequences a fixed-latency multi-cycle unit, issues flush pulses and counts stalls.
module pipe_stall_ctrl #(
   parameter int NSTAGE   = 6,
   parameter int MC_STAGE = 3,
   parameter int MC_LAT   = 32,
   parameter int CNT_W    = 6,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              mc_start,
   input  logic              flush_req,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [PERF_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [NSTAGE-1:0] MC_BIT   = NSTAGE'(1) << MC_STAGE;
   localparam logic [CNT_W-1:0]  LAT_M1   = CNT_W'(MC_LAT - 1);
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_flush;
   logic                r_mc_busy;
   logic                r_mc_done;
   logic [PERF_W-1:0]   r_stall_cycles;

   logic [NSTAGE-1:0]   w_req;
   logic [NSTAGE-1:0]   w_mask;
   logic [NSTAGE-1:0]   w_stall;

   // Thermometer mask: every stage at or below the highest requester holds.
   always_comb begin
      logic v_acc;
      w_req  = stallreq | ((r_state == S_BUSY) ? MC_BIT : '0);
      w_mask = '0;
      v_acc  = 1'b0;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         v_acc     = v_acc | w_req[i];
         w_mask[i] = v_acc;
      end
      w_stall = (rst || r_flush) ? '0 : w_mask;
   end

   // Registered flush pulse and saturating count of front-end stall cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush        <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_flush <= flush_req;
         if (w_stall[0] && (r_stall_cycles != PERF_MAX)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
         end else begin
            r_stall_cycles <= r_stall_cycles;
         end
      end
   end

   // Multi-cycle sequencer; a flush aborts any op in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_mc_busy <= 1'b0;
         r_mc_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_mc_done <= 1'b0;
               if (mc_start && !flush_req) begin
                  r_state   <= S_BUSY;
                  r_cnt     <= LAT_M1;
                  r_mc_busy <= 1'b1;
               end else begin
                  r_state   <= S_IDLE;
                  r_mc_busy <= 1'b0;
               end
            end
            S_BUSY: begin
               if (flush_req) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_mc_busy <= 1'b0;
                  r_mc_done <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state   <= S_DONE;
                  r_mc_busy <= 1'b0;
                  r_mc_done <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt - CNT_W'(1);
                  r_mc_busy <= 1'b1;
                  r_mc_done <= 1'b0;
               end
            end
            S_DONE: begin
               r_mc_done <= 1'b0;
               if (mc_start && !flush_req) begin
                  r_state   <= S_BUSY;
                  r_cnt     <= LAT_M1;
                  r_mc_busy <= 1'b1;
               end else begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_mc_busy <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_cnt     <= '0;
               r_mc_busy <= 1'b0;
               r_mc_done <= 1'b0;
            end
         endcase
      end
   end

   assign stall        = w_stall;
   assign flush        = r_flush;
   assign mc_busy      = r_mc_busy;
   assign mc_done      = r_mc_done;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (short/long latency) share stimulus and are
// compared every cycle against a remaining-cycles reference model.
module tb_pipe_stall_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [5:0] stallreq;
   logic       mc_start;
   logic       flush_req;

   logic [5:0]  a_stall, b_stall;
   logic        a_flush, b_flush, a_mc_busy, b_mc_busy, a_mc_done, b_mc_done;
   logic [3:0]  a_stall_cycles;
   logic [31:0] b_stall_cycles;

   pipe_stall_ctrl #(.NSTAGE(6), .MC_STAGE(3), .MC_LAT(4), .CNT_W(6), .PERF_W(4)) dut_a (
      .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start), .flush_req(flush_req),
      .stall(a_stall), .flush(a_flush), .mc_busy(a_mc_busy), .mc_done(a_mc_done),
      .stall_cycles(a_stall_cycles));

   pipe_stall_ctrl #(.NSTAGE(6), .MC_STAGE(3), .MC_LAT(32), .CNT_W(6), .PERF_W(32)) dut_b (
      .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start), .flush_req(flush_req),
      .stall(b_stall), .flush(b_flush), .mc_busy(b_mc_busy), .mc_done(b_mc_done),
      .stall_cycles(b_stall_cycles));

   int errors = 0;
   int checks = 0;

   int     m_lat [2] = '{4, 32};
   longint m_max [2] = '{64'd15, 64'hFFFF_FFFF};
   int     m_rem [2];
   bit     m_done[2];
   longint m_cnt [2];
   bit     m_flush;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] exp_stall(input logic [5:0] sr, input bit busy, input bit fl,
                                            input bit rs);
      int h = -1;
      for (int i = 0; i < 6; i++) if (sr[i]) h = i;
      if (busy && h < 3) h = 3;
      if (fl || rs || h < 0) return 6'd0;
      return 6'((64'd1 << (h + 1)) - 64'd1);
   endfunction

   task automatic step(input logic [5:0] sr, input logic ms, input logic fr, input logic rs);
      logic [5:0] e_st [2];
      stallreq  = sr;
      mc_start  = ms;
      flush_req = fr;
      rst       = rs;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e_st[k] = exp_stall(sr, m_rem[k] > 0, m_flush, rs);
         check_eq(k == 0 ? "a_stall" : "b_stall", k == 0 ? a_stall : b_stall, e_st[k]);
         check_eq(k == 0 ? "a_flush" : "b_flush", k == 0 ? a_flush : b_flush, m_flush);
         check_eq(k == 0 ? "a_busy" : "b_busy", k == 0 ? a_mc_busy : b_mc_busy, m_rem[k] > 0);
         check_eq(k == 0 ? "a_done" : "b_done", k == 0 ? a_mc_done : b_mc_done, m_done[k]);
         check_eq(k == 0 ? "a_cycles" : "b_cycles",
                  k == 0 ? 64'(a_stall_cycles) : 64'(b_stall_cycles), m_cnt[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rs) begin
            m_rem[k] = 0; m_done[k] = 1'b0; m_cnt[k] = 0;
         end else begin
            if (e_st[k][0]) m_cnt[k] = (m_cnt[k] == m_max[k]) ? m_max[k] : m_cnt[k] + 1;
            if (m_rem[k] > 0) begin
               if (fr) m_rem[k] = 0;
               else if (m_rem[k] == 1) begin m_rem[k] = 0; m_done[k] = 1'b1; end
               else m_rem[k] = m_rem[k] - 1;
            end else begin
               m_done[k] = 1'b0;
               if (ms && !fr) m_rem[k] = m_lat[k];
            end
         end
      end
      m_flush = rs ? 1'b0 : fr;
      #1;
   endtask

   initial begin
      m_rem = '{0, 0}; m_done = '{1'b0, 1'b0}; m_cnt = '{0, 0}; m_flush = 1'b0;
      rst = 1'b1; stallreq = '0; mc_start = 1'b0; flush_req = 1'b0;
      @(posedge clk); #1;

      // reset held, then idle
      step(6'd0, 1'b0, 1'b0, 1'b1);
      step(6'd0, 1'b0, 1'b0, 1'b1);
      step(6'd0, 1'b0, 1'b0, 1'b0);

      // load-use hold in ID
      step(6'b000100, 1'b0, 1'b0, 1'b0);
      check_eq("t2_cycles", 64'(a_stall_cycles), 64'd1);
      step(6'd0, 1'b0, 1'b0, 1'b0);

      // short multi-cycle op: four busy cycles then one done cycle
      step(6'd0, 1'b1, 1'b0, 1'b1);
      step(6'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_eq("t3_busy", 64'(a_mc_busy), (i < 4) ? 64'd1 : 64'd0);
         check_eq("t3_stall", 64'(a_stall), (i < 4) ? 64'h0F : 64'h00);
         check_eq("t3_done", 64'(a_mc_done), (i == 4) ? 64'd1 : 64'd0);
         step(6'd0, 1'b0, 1'b0, 1'b0);
      end
      check_eq("t3_cycles", 64'(a_stall_cycles), 64'd4);

      // long op aborted by flush
      step(6'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(6'd0, 1'b0, 1'b0, 1'b0);
      step(6'd0, 1'b0, 1'b1, 1'b0);
      check_eq("t4_flush", 64'(b_flush), 64'd1);
      check_eq("t4_busy", 64'(b_mc_busy), 64'd0);
      check_eq("t4_stall", 64'(b_stall), 64'd0);
      for (int i = 0; i < 40; i++) step(6'd0, 1'b0, 1'b0, 1'b0);

      // external request above the multi-cycle stage wins
      step(6'd0, 1'b1, 1'b0, 1'b0);
      step(6'b010000, 1'b0, 1'b0, 1'b0);
      step(6'b010000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(6'd0, 1'b0, 1'b0, 1'b0);

      // saturation of the narrow stall counter
      step(6'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(6'b000001, 1'b0, 1'b0, 1'b0);
      check_eq("t6_sat", 64'(a_stall_cycles), 64'hF);
      step(6'd0, 1'b0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] sr;
         sr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         step(sr, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 149) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
